// File: rtl/alu_reg.sv
// alu_reg: registered single-cycle integer ALU.
// Two WIDTH-bit operands and a 3-bit opcode are sampled on in_valid. The result and
// the zero/neg/carry/ovf flags are registered together and held until the next
// accepted operation. out_valid pulses for one cycle per accepted operation.
// Optional build macro ALU_MUL_EN: opcode 7 becomes an unsigned multiply (low half
// of the product, carry flags a nonzero high half). Without it, opcode 7 is PASSA
// and no multiplier is built.
// WIDTH must be a power of two between 4 and 64.

module alu_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ans,
  output logic             out_valid,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  // Shift amount width; always derived from WIDTH.
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpShl = 3'd5,
    OpShr = 3'd6,
    OpSeven = 3'd7
  } op_e;

  // Registered state.
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Combinational result of the current operation.
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;

  // Arithmetic helpers, one bit wider to expose carry/borrow.
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH:0]   shr_full;
  logic [SHW-1:0]   sh_amt;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  // Shared datapath terms for all opcodes.
  always_comb begin
    sh_amt   = b[SHW-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    // Extra bit above (SHL) or below (SHR) catches the last bit shifted out;
    // a zero shift leaves that bit at 0, giving carry=0.
    shl_full = {1'b0, a} << sh_amt;
    shr_full = {a, 1'b0} >> sh_amt;
`ifdef ALU_MUL_EN
    prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
  end

  // Opcode decode; every opcode value yields a defined result and flags.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (op_e'(code))
      OpAdd: begin
        res       = add_full[WIDTH-1:0];
        res_carry = add_full[WIDTH];
        // Same-sign operands producing a result of the other sign.
        res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        res       = sub_full[WIDTH-1:0];
        res_carry = sub_full[WIDTH];  // borrow: a < b unsigned
        res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: res = a & b;
      OpOr:  res = a | b;
      OpXor: res = a ^ b;
      OpShl: begin
        res       = shl_full[WIDTH-1:0];
        res_carry = shl_full[WIDTH];
      end
      OpShr: begin
        res       = shr_full[WIDTH:1];
        res_carry = shr_full[0];
      end
      OpSeven: begin
`ifdef ALU_MUL_EN
        res       = prod[WIDTH-1:0];
        res_carry = |prod[2*WIDTH-1:WIDTH];
`else
        res       = a;
`endif
      end
      default: begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
      end
    endcase
  end

  // Next-state: load a new result on in_valid, otherwise hold everything.
  always_comb begin
    valid_d = in_valid;
    ans_d   = ans_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      ans_d   = res;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
      carry_d = res_carry;
      ovf_d   = res_ovf;
    end
  end

  // State registers; asynchronous reset clears the result (zero flag set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ans_q   <= ans_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ans       = ans_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_reg.sv
// Scoreboard bench for alu_reg (WIDTH=8): the driver pushes hand-computed expected
// results, a monitor pops and compares whenever out_valid is seen.

module tb_alu_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   code = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] ans;
  logic         out_valid, zero, neg, carry, ovf;

  alu_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .code      (code),
    .a         (a),
    .b         (b),
    .ans       (ans),
    .out_valid (out_valid),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] ans;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    int unsigned  id;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned next_id = 0;

`ifdef ALU_MUL_EN
  localparam logic OP7_CARRY = 1'b1;
`else
  localparam logic OP7_CARRY = 1'b0;
`endif

  // Drive one operation on the falling edge and queue its expected result.
  task automatic issue(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e_ans, input logic e_carry, input logic e_ovf);
    exp_t e;
    @(negedge clk);
    code     = c;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    e.ans    = e_ans;
    e.zero   = (e_ans == '0);
    e.neg    = e_ans[W-1];
    e.carry  = e_carry;
    e.ovf    = e_ovf;
    e.id     = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out_valid: got ans=%0h, expected no output", ans);
        end else begin
          e = sb.pop_front();
          if ({ans, zero, neg, carry, ovf} !== {e.ans, e.zero, e.neg, e.carry, e.ovf}) begin
            n_err++;
            $display("FAIL vec%0d: got ans=%0h z=%b n=%b c=%b v=%b, expected ans=%0h z=%b n=%b c=%b v=%b",
                     e.id, ans, zero, neg, carry, ovf, e.ans, e.zero, e.neg, e.carry, e.ovf);
          end
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [W-1:0] hold_ans;
    repeat (2) @(negedge clk);
    check("reset_ans", ans, 0);
    check("reset_zero", zero, 1);
    check("reset_valid", out_valid, 0);
    rst_n = 1'b1;

    // code, a, b, ans, carry, ovf
    issue(3'd1, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0);  // SUB 1-0
    issue(3'd2, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0);  // AND -> zero
    issue(3'd0, 8'h02, 8'h01, 8'h03, 1'b0, 1'b0);  // ADD
    issue(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);  // ADD carry out
    issue(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);  // ADD signed overflow
    issue(3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);  // ADD both
    issue(3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);  // SUB borrow
    issue(3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);  // SUB signed overflow
    issue(3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0);  // SHL 1
    issue(3'd6, 8'h81, 8'h09, 8'h40, 1'b1, 1'b0);  // SHR, upper b bits ignored
    issue(3'd5, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0);  // SHL 0
    issue(3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0);  // SHR 0
    issue(3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0);  // SHL max
    issue(3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0);  // SHR max
    issue(3'd3, 8'h5A, 8'hA5, 8'hFF, 1'b0, 1'b0);  // OR
    issue(3'd4, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0);  // XOR
    issue(3'd7, 8'h10, 8'h11, 8'h10, OP7_CARRY, 1'b0);  // PASSA / MUL
    hold_ans = 8'h10;
    @(negedge clk);
    in_valid = 1'b0;

    // Hold: no new operation for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ans", ans, hold_ans);
      check("hold_valid", out_valid, 0);
    end
    drain();

    // Asynchronous reset right after a result is registered.
    issue(3'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ans", ans, 0);
    check("async_rst_zero", zero, 1);
    check("async_rst_valid", out_valid, 0);
    sb.delete();
    // in_valid stays high across an edge while reset is held.
    @(posedge clk);
    #1;
    check("rst_hold_ans", ans, 0);
    check("rst_hold_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    issue(3'd4, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);  // recovery after reset
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
